tb_run_ctrl: RTL

Synthesizable run controller that replaces the hard-coded reset pulse and fixed stop delay in the processor testbench.
- Sequences the core reset after the external reset is released.
- Counts cycles and retired instructions across NUM_HARTS harts.
- Detects end of test from a tohost store, a self-loop halt (jal x0,0) or a watchdog timeout.
- Reports a sticky status that the bench polls before calling $stop.
Sits between the bench and TOP_DUT and observes each hart's data-memory write port and retire port.

---
 rtl/tb_run_pkg.sv | 26 ++
 rtl/hart_loop_det.sv | 56 +++++
 rtl/tb_run_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/tb_run_pkg.sv
// Shared types and helpers for the testbench run controller.
// The status enum doubles as the controller's FSM state encoding.
package tb_run_pkg;

   typedef enum logic [2:0] {
      ST_HOLD    = 3'd0,
      ST_RUN     = 3'd1,
      ST_PASS    = 3'd2,
      ST_FAIL    = 3'd3,
      ST_HALT    = 3'd4,
      ST_TIMEOUT = 3'd5
   } run_status_e;

   localparam logic [31:0] TOHOST_ADDR_DEF = 32'h0000_0100;
   localparam int          MAX_HARTS       = 8;

   function automatic logic [3:0] popcount(input logic [MAX_HARTS-1:0] v);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < MAX_HARTS; i++) begin
         n = n + {3'b000, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/hart_loop_det.sv
// Per-hart self-loop detector: flags a halt when the same PC retires
// LOOP_LIMIT times in a row (the jal x0,0 idiom used to park a core).
module hart_loop_det #(
   parameter int XLEN       = 32,
   parameter int LOOP_LIMIT = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            clear,
   input  logic            retire_valid,
   input  logic [XLEN-1:0] retire_pc,
   output logic            halt,
   output logic [XLEN-1:0] halt_pc
);

   localparam int CW = $clog2(LOOP_LIMIT + 1);

   logic [XLEN-1:0] pc_q, pc_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            same_pc;

   assign same_pc = (retire_pc == pc_q);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q  <= '0;
         cnt_q <= '0;
      end else begin
         pc_q  <= pc_d;
         cnt_q <= cnt_d;
      end
   end

   always_comb begin
      pc_d  = pc_q;
      cnt_d = cnt_q;
      if (clear) begin
         pc_d  = '0;
         cnt_d = '0;
      end else if (retire_valid) begin
         if (same_pc) begin
            if (cnt_q != CW'(LOOP_LIMIT)) cnt_d = cnt_q + 1'b1;
         end else begin
            pc_d  = retire_pc;
            cnt_d = CW'(1);
         end
      end
   end

   // Fires in the cycle of the LOOP_LIMIT-th retire, not one cycle later.
   always_comb begin
      halt    = !clear && retire_valid && same_pc && (cnt_q >= CW'(LOOP_LIMIT - 1));
      halt_pc = retire_pc;
   end

endmodule

// File: rtl/tb_run_ctrl.sv
// Run controller: sequences core reset, counts cycles/retires in RUN and
// latches the first end-of-test event (tohost exit, self-loop halt, timeout).
module tb_run_ctrl
   import tb_run_pkg::*;
#(
   parameter int              XLEN           = 32,
   parameter int              NUM_HARTS      = 1,
   parameter int              RST_CYCLES     = 4,
   parameter int              TIMEOUT_CYCLES = 200,
   parameter logic [XLEN-1:0] TOHOST_ADDR    = TOHOST_ADDR_DEF,
   parameter int              LOOP_LIMIT     = 8,
   parameter int              CNT_W          = 32,
   localparam int             EH_W           = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_HARTS-1:0]      mem_we,
   input  logic [NUM_HARTS*XLEN-1:0] mem_addr,
   input  logic [NUM_HARTS*XLEN-1:0] mem_wdata,
   input  logic [NUM_HARTS-1:0]      retire_valid,
   input  logic [NUM_HARTS*XLEN-1:0] retire_pc,
   output logic                      core_reset,
   output logic                      running,
   output logic                      done,
   output logic [2:0]                status,
   output logic [XLEN-1:0]           exit_code,
   output logic [EH_W-1:0]           end_hart,
   output logic [CNT_W-1:0]          cycle_count,
   output logic [CNT_W-1:0]          instret_total
);

   localparam int HC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

   run_status_e     state_q, state_d;
   logic [HC_W-1:0] hold_q, hold_d;
   logic [CNT_W-1:0] cyc_q, cyc_d, inst_q, inst_d;
   logic [XLEN-1:0] exit_q, exit_d;
   logic [EH_W-1:0] eh_q, eh_d;

   logic                 in_run;
   logic [NUM_HARTS-1:0] halt_v;
   logic [XLEN-1:0]      halt_pc_a [NUM_HARTS];

   logic            exit_hit, halt_hit;
   logic [EH_W-1:0] exit_hart, halt_hart;
   logic [XLEN-1:0] exit_data, halt_pc_sel;
   logic [MAX_HARTS-1:0] rv_ext;
   logic [CNT_W:0]  cyc_sum, inst_sum;

   assign in_run = (state_q == ST_RUN);

   // Detectors are held clear outside RUN so HOLD and terminal inputs are ignored.
   for (genvar g = 0; g < NUM_HARTS; g++) begin : g_det
      hart_loop_det #(
         .XLEN       (XLEN),
         .LOOP_LIMIT (LOOP_LIMIT)
      ) u_det (
         .clk          (clk),
         .reset        (reset),
         .clear        (!in_run),
         .retire_valid (retire_valid[g]),
         .retire_pc    (retire_pc[g*XLEN +: XLEN]),
         .halt         (halt_v[g]),
         .halt_pc      (halt_pc_a[g])
      );
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_HOLD;
         hold_q  <= '0;
         cyc_q   <= '0;
         inst_q  <= '0;
         exit_q  <= '0;
         eh_q    <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         cyc_q   <= cyc_d;
         inst_q  <= inst_d;
         exit_q  <= exit_d;
         eh_q    <= eh_d;
      end
   end

   // Descending scan so the lowest-index hart is the last (winning) assignment.
   always_comb begin
      exit_hit    = 1'b0;
      exit_hart   = '0;
      exit_data   = '0;
      halt_hit    = 1'b0;
      halt_hart   = '0;
      halt_pc_sel = '0;
      for (int h = NUM_HARTS - 1; h >= 0; h--) begin
         if (mem_we[h] && (mem_addr[h*XLEN +: XLEN] == TOHOST_ADDR) && mem_wdata[h*XLEN]) begin
            exit_hit  = 1'b1;
            exit_hart = EH_W'(h);
            exit_data = mem_wdata[h*XLEN +: XLEN];
         end
         if (halt_v[h]) begin
            halt_hit    = 1'b1;
            halt_hart   = EH_W'(h);
            halt_pc_sel = halt_pc_a[h];
         end
      end
   end

   always_comb begin
      rv_ext                  = '0;
      rv_ext[NUM_HARTS-1:0]   = retire_valid;
      cyc_sum  = {1'b0, cyc_q} + (CNT_W+1)'(1);
      inst_sum = {1'b0, inst_q} + (CNT_W+1)'(popcount(rv_ext));
   end

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      cyc_d   = cyc_q;
      inst_d  = inst_q;
      exit_d  = exit_q;
      eh_d    = eh_q;
      case (state_q)
         ST_HOLD: begin
            if (hold_q == HC_W'(RST_CYCLES - 1)) state_d = ST_RUN;
            else                                 hold_d  = hold_q + 1'b1;
         end
         ST_RUN: begin
            // Event cycle is still counted; counters saturate instead of wrapping.
            cyc_d  = cyc_sum[CNT_W]  ? '1 : cyc_sum[CNT_W-1:0];
            inst_d = inst_sum[CNT_W] ? '1 : inst_sum[CNT_W-1:0];
            if (exit_hit) begin
               state_d = (exit_data == XLEN'(1)) ? ST_PASS : ST_FAIL;
               exit_d  = exit_data >> 1;
               eh_d    = exit_hart;
            end else if (halt_hit) begin
               state_d = ST_HALT;
               exit_d  = halt_pc_sel;
               eh_d    = halt_hart;
            end else if (cyc_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               state_d = ST_TIMEOUT;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      core_reset    = (state_q == ST_HOLD);
      running       = in_run;
      done          = (state_q == ST_PASS) || (state_q == ST_FAIL) ||
                      (state_q == ST_HALT) || (state_q == ST_TIMEOUT);
      status        = state_q;
      exit_code     = exit_q;
      end_hart      = eh_q;
      cycle_count   = cyc_q;
      instret_total = inst_q;
   end

endmodule
